// File: rtl/axi_lite_slave_regfile.sv
// AXI4-Lite register file: register 0 is a read-only ID, registers 1..NUM_REGS-1 are
// byte-writable. Read and write channels run independently, one outstanding transaction each.
module axi_lite_slave_regfile #(
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = 32'hA11E_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_awaddr,
  input  logic [2:0]  s_awprot,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic [31:0] s_araddr,
  input  logic [2:0]  s_arprot,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready
);
  localparam int         IW     = $clog2(NUM_REGS);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wreq_t;

  logic [31:0]   r_regs [NUM_REGS];
  wstate_t       r_wstate, w_wnext;
  rstate_t       r_rstate, w_rnext;
  logic          r_aw_got, r_w_got;
  wreq_t         r_wreq, w_wreq;
  logic [1:0]    r_bresp, r_rresp;
  logic [31:0]   r_rdata;
  logic          w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wok;
  logic [IW-1:0] w_widx, w_ridx;
  logic          w_unused;

  assign w_unused = ^{s_awprot, s_arprot, s_araddr[1:0]};

  // ---------------- state registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_rstate <= R_IDLE;
    end else begin
      r_wstate <= w_wnext;
      r_rstate <= w_rnext;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_wnext = r_wstate;
    unique case (r_wstate)
      W_IDLE:  if (w_commit) w_wnext = W_RESP;
      W_RESP:  if (s_bready) w_wnext = W_IDLE;
      default: w_wnext = W_IDLE;
    endcase
  end

  always_comb begin
    w_rnext = r_rstate;
    unique case (r_rstate)
      R_IDLE:  if (w_ar_hs)  w_rnext = R_DATA;
      R_DATA:  if (s_rready) w_rnext = R_IDLE;
      default: w_rnext = R_IDLE;
    endcase
  end

  // ---------------- outputs (registered state only) ----------------
  always_comb begin
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_arready = (r_rstate == R_IDLE);
    s_rvalid  = (r_rstate == R_DATA);
    if (r_wstate == W_IDLE) begin
      s_awready = ~r_aw_got;
      s_wready  = ~r_w_got;
    end else begin
      s_bvalid  = 1'b1;
    end
  end

  assign s_bresp = r_bresp;
  assign s_rdata = r_rdata;
  assign s_rresp = r_rresp;

  // ---------------- write path ----------------
  assign w_aw_hs = s_awvalid & s_awready;
  assign w_w_hs  = s_wvalid  & s_wready;

  // Whichever half arrived earlier comes from the capture register, the other straight from the bus.
  assign w_wreq.addr = r_aw_got ? r_wreq.addr : s_awaddr;
  assign w_wreq.data = r_w_got  ? r_wreq.data : s_wdata;
  assign w_wreq.strb = r_w_got  ? r_wreq.strb : s_wstrb;

  assign w_commit = (r_wstate == W_IDLE) && (r_aw_got || w_aw_hs) && (r_w_got || w_w_hs);
  assign w_widx   = w_wreq.addr[IW+1:2];
  assign w_wok    = (w_wreq.addr[31:IW+2] == '0) && (w_widx != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_wreq   <= '0;
      r_bresp  <= OKAY;
    end else if (w_commit) begin
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_bresp  <= w_wok ? OKAY : SLVERR;
    end else begin
      if (w_aw_hs) begin
        r_aw_got    <= 1'b1;
        r_wreq.addr <= s_awaddr;
      end
      if (w_w_hs) begin
        r_w_got     <= 1'b1;
        r_wreq.data <= s_wdata;
        r_wreq.strb <= s_wstrb;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit && w_wok) begin
      for (int b = 0; b < 4; b++)
        if (w_wreq.strb[b]) r_regs[w_widx][8*b +: 8] <= w_wreq.data[8*b +: 8];
    end
  end

  // ---------------- read path ----------------
  // Read data is sampled from r_regs before any same-edge commit lands.
  assign w_ar_hs = s_arvalid & s_arready;
  assign w_ridx  = s_araddr[IW+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
      r_rresp <= OKAY;
    end else if (w_ar_hs) begin
      if (s_araddr[31:IW+2] != '0) begin
        r_rdata <= '0;
        r_rresp <= SLVERR;
      end else if (w_ridx == '0) begin
        r_rdata <= ID_VALUE;
        r_rresp <= OKAY;
      end else begin
        r_rdata <= r_regs[w_ridx];
        r_rresp <= OKAY;
      end
    end
  end
endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// Randomized bench for axi_lite_slave_regfile against an array-based register model.
module tb_axi_lite_slave_regfile;
  localparam int          NR = 8;
  localparam logic [31:0] ID = 32'hA11E_0001;

  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
  logic [2:0]  s_awprot = '0, s_arprot = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b1, s_arvalid = 1'b0, s_rready = 1'b1;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;

  int vec = 0, err = 0;
  logic [31:0] m_regs [NR];

  always #5 clk = ~clk;

  axi_lite_slave_regfile #(.NUM_REGS(NR), .ID_VALUE(ID)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (a >= NR*4) return 32'h0;
    if (a / 4 == 0) return ID;
    return m_regs[a / 4];
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [31:0] a);
    return (a >= NR*4) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [1:0] exp_bresp(input logic [31:0] a);
    return (a >= NR*4 || a / 4 == 0) ? 2'b10 : 2'b00;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    if (a < NR*4 && a / 4 != 0)
      for (int b = 0; b < 4; b++) if (st[b]) m_regs[a / 4][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
  endtask

  // ---------------- bus drivers (report timeouts through ok) ----------------
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                          output logic [1:0] resp, output int lat, output bit ok);
    int n;
    bit aw_hs, w_hs;
    @(negedge clk);
    s_awaddr = a; s_wdata = d; s_wstrb = st; s_awprot = 3'($urandom);
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
    n = 0;
    while ((s_awvalid || s_wvalid) && n < 50) begin
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      @(negedge clk); n++;
      if (aw_hs) s_awvalid = 1'b0;
      if (w_hs)  s_wvalid  = 1'b0;
    end
    lat = 0;
    while (!s_bvalid && lat < 50) begin @(negedge clk); lat++; end
    resp = s_bresp;
    ok = (n < 50) && (lat < 50);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp,
                         output int lat, output bit ok);
    int n;
    bit ar_hs;
    @(negedge clk);
    s_araddr = a; s_arprot = 3'($urandom); s_arvalid = 1'b1; s_rready = 1'b1;
    n = 0;
    while (s_arvalid && n < 50) begin
      ar_hs = s_arready;
      @(negedge clk); n++;
      if (ar_hs) s_arvalid = 1'b0;
    end
    lat = 0;
    while (!s_rvalid && lat < 50) begin @(negedge clk); lat++; end
    data = s_rdata; resp = s_rresp;
    ok = (n < 50) && (lat < 50);
    s_arvalid = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    vec++; if ({s_awready, s_wready, s_arready} !== 3'b111) begin err++; $display("FAIL reset_ready: got %b want 111", {s_awready, s_wready, s_arready}); end
    vec++; if ({s_bvalid, s_rvalid} !== 2'b00) begin err++; $display("FAIL reset_valid: got %b want 00", {s_bvalid, s_rvalid}); end
    vec++; if ({s_bresp, s_rresp, s_rdata} !== 36'h0) begin err++; $display("FAIL reset_resp_data: got %h want 0", {s_bresp, s_rresp, s_rdata}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_write_read();
    logic [1:0] resp; logic [31:0] d; int lat; bit ok;
    do_write(32'h8, 32'hDEAD_BEEF, 4'hF, resp, lat, ok);
    model_write(32'h8, 32'hDEAD_BEEF, 4'hF);
    vec++; if (!ok || lat !== 0) begin err++; $display("FAIL wr_latency: got ok=%0d lat=%0d want ok=1 lat=0", ok, lat); end
    vec++; if (resp !== 2'b00) begin err++; $display("FAIL wr_bresp: got %b want 00", resp); end
    do_read(32'h8, d, resp, lat, ok);
    vec++; if (!ok || lat !== 0) begin err++; $display("FAIL rd_latency: got ok=%0d lat=%0d want ok=1 lat=0", ok, lat); end
    vec++; if (d !== 32'hDEAD_BEEF || resp !== 2'b00) begin err++; $display("FAIL rd_deadbeef: got %h/%b want deadbeef/00", d, resp); end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp; logic [31:0] d; int lat; bit ok;
    do_write(32'h4, 32'hAABB_CCDD, 4'hF, resp, lat, ok);
    model_write(32'h4, 32'hAABB_CCDD, 4'hF);
    @(negedge clk);
    s_wdata = 32'h1122_3344; s_wstrb = 4'b0101; s_wvalid = 1'b1; s_bready = 1'b1;
    @(negedge clk);
    s_wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vec++; if ({s_wready, s_awready, s_bvalid} !== 3'b010) begin err++; $display("FAIL w_first_wait%0d: got wr/awr/bv=%b want 010", k, {s_wready, s_awready, s_bvalid}); end
      if (k < 2) @(negedge clk);
    end
    s_awaddr = 32'h4; s_awvalid = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0;
    vec++; if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin err++; $display("FAIL w_first_bresp: got bv=%b resp=%b want 1/00", s_bvalid, s_bresp); end
    @(negedge clk);
    model_write(32'h4, 32'h1122_3344, 4'b0101);
    do_read(32'h4, d, resp, lat, ok);
    vec++; if (!ok || d !== 32'hAA22_CC44 || d !== exp_rdata(32'h4)) begin err++; $display("FAIL w_first_strobe: got %h want aa22cc44", d); end
  endtask

  task automatic test_id_reg();
    logic [1:0] resp; logic [31:0] d; int lat; bit ok;
    do_read(32'h0, d, resp, lat, ok);
    vec++; if (!ok || d !== ID || resp !== 2'b00) begin err++; $display("FAIL id_read: got %h/%b want %h/00", d, resp, ID); end
    do_write(32'h0, 32'h1234_5678, 4'hF, resp, lat, ok);
    vec++; if (!ok || resp !== 2'b10) begin err++; $display("FAIL id_write_resp: got %b want 10", resp); end
    do_read(32'h0, d, resp, lat, ok);
    vec++; if (!ok || d !== ID) begin err++; $display("FAIL id_reread: got %h want %h", d, ID); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [31:0] d; int lat; bit ok;
    logic [31:0] oor [3];
    oor[0] = 32'h100; oor[1] = 32'h104; oor[2] = 32'h11C;
    do_read(32'h100, d, resp, lat, ok);
    vec++; if (!ok || d !== 32'h0 || resp !== 2'b10) begin err++; $display("FAIL oor_read: got %h/%b want 0/10", d, resp); end
    for (int i = 0; i < 3; i++) begin
      do_write(oor[i], $urandom, 4'hF, resp, lat, ok);
      vec++; if (!ok || resp !== 2'b10) begin err++; $display("FAIL oor_write_%h: got %b want 10", oor[i], resp); end
    end
    for (int i = 1; i < NR; i++) begin
      do_read(32'(i * 4), d, resp, lat, ok);
      vec++; if (!ok || d !== m_regs[i]) begin err++; $display("FAIL oor_unchanged_r%0d: got %h want %h", i, d, m_regs[i]); end
    end
  endtask

  task automatic test_bready_stall();
    logic [1:0] resp; logic [31:0] d, wd; int lat; bit ok;
    wd = $urandom;
    @(negedge clk);
    s_bready = 1'b0; s_awaddr = 32'hC; s_wdata = wd; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    model_write(32'hC, wd, 4'hF);
    for (int k = 0; k < 10; k++) begin
      vec++; if ({s_bvalid, s_bresp, s_awready, s_wready} !== 5'b10000) begin err++; $display("FAIL stall_cycle%0d: got bv/bresp/awr/wr=%b want 10000", k, {s_bvalid, s_bresp, s_awready, s_wready}); end
      if (k == 4) begin
        do_read(32'hC, d, resp, lat, ok);
        vec++; if (!ok || d !== wd || resp !== 2'b00) begin err++; $display("FAIL stall_read: got %h/%b want %h/00", d, resp, wd); end
      end else @(negedge clk);
    end
    s_bready = 1'b1;
    @(negedge clk);
    vec++; if ({s_bvalid, s_awready, s_wready} !== 3'b011) begin err++; $display("FAIL stall_release: got bv/awr/wr=%b want 011", {s_bvalid, s_awready, s_wready}); end
  endtask

  task automatic test_collision();
    logic [1:0] resp; logic [31:0] d, old, wd; int lat; bit ok;
    old = m_regs[5]; wd = ~old;
    @(negedge clk);
    s_awaddr = 32'h14; s_wdata = wd; s_wstrb = 4'hF; s_araddr = 32'h14;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1; s_bready = 1'b1; s_rready = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    vec++; if (s_rvalid !== 1'b1 || s_rdata !== old) begin err++; $display("FAIL collide_old: got rv=%b %h want 1 %h", s_rvalid, s_rdata, old); end
    model_write(32'h14, wd, 4'hF);
    @(negedge clk);
    do_read(32'h14, d, resp, lat, ok);
    vec++; if (!ok || d !== wd) begin err++; $display("FAIL collide_new: got %h want %h", d, wd); end
  endtask

  task automatic test_back_to_back();
    int cnt; logic [31:0] a, wd;
    a = 32'($urandom_range(1, NR-1) * 4);
    @(negedge clk);
    s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1; cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (s_arready) cnt++;
      if (s_rvalid) begin
        vec++; if (s_rdata !== exp_rdata(a)) begin err++; $display("FAIL b2b_rdata: got %h want %h", s_rdata, exp_rdata(a)); end
      end
      @(negedge clk);
    end
    s_arvalid = 1'b0;
    vec++; if (cnt !== 10) begin err++; $display("FAIL b2b_reads: got %0d want 10", cnt); end
    @(negedge clk);
    wd = $urandom;
    s_awaddr = a; s_wdata = wd; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1; cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (s_awready && s_wready) cnt++;
      @(negedge clk);
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    model_write(a, wd, 4'hF);
    vec++; if (cnt !== 10) begin err++; $display("FAIL b2b_writes: got %0d want 10", cnt); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [1:0] resp; logic [31:0] a, d, wd; logic [3:0] st; int lat; bit ok;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 0) a = $urandom_range(NR*4, 4095);
      else a = 32'($urandom_range(0, NR-1) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom; st = 4'($urandom);
        do_write(a, wd, st, resp, lat, ok);
        vec++; if (!ok || resp !== exp_bresp(a)) begin err++; $display("FAIL rand_wr a=%h: got %b want %b", a, resp, exp_bresp(a)); end
        model_write(a, wd, st);
      end else begin
        do_read(a, d, resp, lat, ok);
        vec++; if (!ok || d !== exp_rdata(a) || resp !== exp_rresp(a)) begin err++; $display("FAIL rand_rd a=%h: got %h/%b want %h/%b", a, d, resp, exp_rdata(a), exp_rresp(a)); end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [1:0] resp; logic [31:0] d; int lat; bit ok;
    @(negedge clk);
    s_rready = 1'b0; s_araddr = 32'h4; s_arvalid = 1'b1;
    @(negedge clk);
    s_arvalid = 1'b0;
    vec++; if (s_rvalid !== 1'b1) begin err++; $display("FAIL mid_read_rvalid: got %b want 1", s_rvalid); end
    #2 rst = 1'b1;
    #1;
    vec++; if ({s_rvalid, s_arready, s_rdata} !== {2'b01, 32'h0}) begin err++; $display("FAIL async_reset: got rv/arr=%b rdata=%h want 01/0", {s_rvalid, s_arready}, s_rdata); end
    @(negedge clk);
    rst = 1'b0; s_rready = 1'b1;
    model_reset();
    for (int i = 0; i < NR; i++) begin
      do_read(32'(i * 4), d, resp, lat, ok);
      vec++; if (!ok || d !== exp_rdata(32'(i * 4))) begin err++; $display("FAIL post_reset_r%0d: got %h want %h", i, d, exp_rdata(32'(i * 4))); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_w_before_aw();
    test_id_reg();
    test_out_of_range();
    test_bready_stall();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
